// File: rtl/clkdiv_pkg.sv
// Shared definitions for the scope clock-divider scheduler.
package clkdiv_pkg;

  localparam int DEFAULT_DIV  = 7;
  localparam int DEFAULT_HIGH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  // A ratio is usable only if both phases get at least one cycle.
  function automatic logic cfg_legal(input int unsigned div, input int unsigned high);
    return (div >= 2) && (high >= 1) && (high <= div - 1);
  endfunction

endpackage

// File: rtl/clkdiv_sched_if.sv
// Configuration handshake between the scope controller and the divider.
interface clkdiv_sched_if #(
  parameter int CNT_W = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, cfg_high, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_core.sv
// Period counter with registered clk_out/tick decode.
// Outputs are decoded from the next count so they line up with cnt.
module clkdiv_core #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_boundary,
  output logic             o_clk_out,
  output logic             o_tick
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             r_tick;

  assign o_boundary = (r_cnt == i_div - ONE);
  assign o_clk_out  = r_clk_out;
  assign o_tick     = r_tick;

  // Next count: wrap at the period end, hold at zero when stopped or restarting.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_en && !i_restart && !o_boundary)
      w_cnt_nxt = r_cnt + ONE;
  end

  // Count register and registered waveform decode; reset kills clk_out at once.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= i_en && (w_cnt_nxt < i_high);
      r_tick    <= i_en && (w_cnt_nxt == '0);
    end
  end
endmodule

// File: rtl/clkdiv_sched.sv
// Divider scheduler: run/stop FSM, config handshake and shadow ratio.
// New ratios and stops only take effect on period boundaries.
module clkdiv_sched #(
  parameter int CNT_W        = 4,
  parameter int DEFAULT_DIV  = clkdiv_pkg::DEFAULT_DIV,
  parameter int DEFAULT_HIGH = clkdiv_pkg::DEFAULT_HIGH
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         run,
  clkdiv_sched_if.slave cfg,
  output logic         clk_out,
  output logic         tick,
  output logic [1:0]   state
);
  import clkdiv_pkg::*;

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);

  state_t           r_state;
  logic [CNT_W-1:0] r_div, r_high;
  logic [CNT_W-1:0] r_sdiv, r_shigh;
  logic             r_cfg_err;

  logic w_ready, w_acc, w_legal, w_load;
  logic w_core_bnd, w_bnd, w_en_nxt, w_restart;

  assign w_ready   = (r_state != ST_PEND);
  assign w_acc     = cfg.cfg_valid && w_ready;
  assign w_legal   = cfg_legal(32'(cfg.cfg_div), 32'(cfg.cfg_high));
  assign w_load    = w_acc && w_legal;
  assign w_bnd     = w_core_bnd && (r_state != ST_IDLE);
  // Counter keeps going unless we sit in IDLE or are stopping at this boundary.
  assign w_en_nxt  = (r_state == ST_IDLE) ? run : !(w_bnd && !run);
  assign w_restart = (r_state == ST_IDLE);

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = r_cfg_err;
  assign state         = r_state;

  // Run/stop FSM with active and shadow ratio registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_div     <= DIV_RST;
      r_high    <= HIGH_RST;
      r_sdiv    <= '0;
      r_shigh   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_acc && !w_legal;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_div  <= cfg.cfg_div;
            r_high <= cfg.cfg_high;
          end
          if (run) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_bnd && !run) begin
            // Stopping: no later boundary will come, so load the ratio directly.
            r_state <= ST_IDLE;
            if (w_load) begin
              r_div  <= cfg.cfg_div;
              r_high <= cfg.cfg_high;
            end
          end else if (w_load) begin
            r_sdiv  <= cfg.cfg_div;
            r_shigh <= cfg.cfg_high;
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_bnd) begin
            r_div   <= r_sdiv;
            r_high  <= r_shigh;
            r_state <= run ? ST_RUN : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  clkdiv_core #(.CNT_W(CNT_W)) u_core (
    .clock      (clock),
    .rst_n      (rst_n),
    .i_en       (w_en_nxt),
    .i_restart  (w_restart),
    .i_div      (r_div),
    .i_high     (r_high),
    .o_boundary (w_core_bnd),
    .o_clk_out  (clk_out),
    .o_tick     (tick)
  );
endmodule
